// File: rtl/gcd_pkg.sv
// Shared types and helpers for the gcd_unit callee: state encoding, default width,
// and the width function for the common power-of-two counter k.
package gcd_pkg;

  localparam int GCD_WIDTH_DEFAULT = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STRIP2 = 3'd1;
  localparam logic [2:0] ST_ODDA   = 3'd2;
  localparam logic [2:0] ST_REDUCE = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    STRIP2 = ST_STRIP2,
    ODDA   = ST_ODDA,
    REDUCE = ST_REDUCE,
    FINISH = ST_FINISH
  } gcd_state_e;

  function automatic int k_w(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One binary-GCD reduction step: halve an even b, otherwise subtract the smaller
// odd operand from the larger, keeping a as the smaller odd value.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a_r,
  input  logic [WIDTH-1:0] b_r,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             done
);

  always_comb begin
    a_nxt = a_r;
    b_nxt = b_r;
    done  = 1'b0;
    if (b_r == '0) begin
      done = 1'b1;
    end else if (!b_r[0]) begin
      b_nxt = b_r >> 1;
    end else if (a_r > b_r) begin
      a_nxt = b_r;
      b_nxt = a_r - b_r;
    end else begin
      b_nxt = b_r - a_r;
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// Binary (Stein) GCD callee on the req/busy/return protocol, one step per cycle.
// Optional busy-cycle counter output gcd_cycles when GCD_CYCLE_COUNT_EN is defined.
//
//   state  | meaning
//   IDLE   | waiting for gcd_req; accepts and latches operands
//   STRIP2 | removing common factors of two, counting them in k
//   ODDA   | making a odd
//   REDUCE | subtract/halve until b is zero
//   FINISH | publish result, drop busy
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gcd_a,
  input  logic [WIDTH-1:0] gcd_b,
  input  logic             gcd_req,
  output logic             gcd_busy,
  output logic [WIDTH-1:0] gcd_return
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [7:0]       gcd_cycles
`endif
);

  localparam int K_W = k_w(WIDTH);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] ret_q, ret_d;

  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_b;
  logic             step_done;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a_r   (a_q),
    .b_r   (b_q),
    .a_nxt (step_a),
    .b_nxt (step_b),
    .done  (step_done)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    res_d   = res_q;
    busy_d  = busy_q;
    ret_d   = ret_q;
    case (state_q)
      IDLE: begin
        if (gcd_req) begin
          a_d    = gcd_a;
          b_d    = gcd_b;
          k_d    = '0;
          busy_d = 1'b1;
          if (gcd_a == '0 || gcd_b == '0) begin
            res_d   = gcd_a | gcd_b;
            state_d = FINISH;
          end else begin
            state_d = STRIP2;
          end
        end
      end
      STRIP2: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + K_W'(1);
        end else begin
          state_d = ODDA;
        end
      end
      ODDA: begin
        if (!a_q[0]) a_d = a_q >> 1;
        else         state_d = REDUCE;
      end
      REDUCE: begin
        if (step_done) begin
          res_d   = a_q << k_q;
          state_d = FINISH;
        end else begin
          a_d = step_a;
          b_d = step_b;
        end
      end
      FINISH: begin
        ret_d   = res_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      ret_q   <= ret_d;
    end
  end

  assign gcd_busy   = busy_q;
  assign gcd_return = ret_q;

`ifdef GCD_CYCLE_COUNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cycles_q, cycles_d;

  // cnt_q holds the busy cycles already elapsed, so FINISH publishes one more
  always_comb begin
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    if (state_q == IDLE && gcd_req) cnt_d = '0;
    else if (busy_q)                cnt_d = sat_inc8(cnt_q);
    if (state_q == FINISH)          cycles_d = sat_inc8(cnt_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      cycles_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
    end
  end

  assign gcd_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Scoreboard bench for gcd_unit: stimulus pushes hand-computed results, a monitor
// pops and compares each time gcd_busy falls.
module tb_gcd_unit;

  localparam int W = 32;
  localparam int MAX_BUSY = 4 * W + 4;

  typedef struct {
    logic [W-1:0] ret;
    int           exact_busy;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] gcd_a = '0;
  logic [W-1:0] gcd_b = '0;
  logic         gcd_req = 1'b0;
  logic         gcd_busy;
  logic [W-1:0] gcd_return;
`ifdef GCD_CYCLE_COUNT_EN
  logic [7:0]   gcd_cycles;
`endif

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic busy_prev = 1'b0;
  int   busy_len = 0;

  gcd_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .gcd_a      (gcd_a),
    .gcd_b      (gcd_b),
    .gcd_req    (gcd_req),
    .gcd_busy   (gcd_busy),
    .gcd_return (gcd_return)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .gcd_cycles (gcd_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gcd_busy && n < max);
    if (gcd_busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: busy still high after %0d cycles, expected low", n);
    end
  endtask

  // hold: extra accept-side edges to keep req high (ignored by a busy DUT)
  task automatic call(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] want, input int exact, input int hold);
    exp_t e;
    @(negedge clk);
    gcd_a   = a;
    gcd_b   = b;
    gcd_req = 1'b1;
    e.ret = want;
    e.exact_busy = exact;
    sb.push_back(e);
    #1 check("no_comb_path", {31'b0, gcd_busy}, 0);
    @(posedge clk);
    #1 check("accept", {31'b0, gcd_busy}, 1);
    gcd_a = $urandom;
    gcd_b = $urandom;
    repeat (hold) @(posedge clk);
    #1 gcd_req = 1'b0;
    wait_idle(MAX_BUSY + 8);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busy_prev = 1'b0;
      busy_len  = 0;
    end else begin
      if (gcd_busy) begin
        busy_len++;
      end else if (busy_prev) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_return: got 0x%0h, expected no call", gcd_return);
        end else begin
          e = sb.pop_front();
          check("gcd_return", gcd_return, e.ret);
          if (e.exact_busy != 0) check("busy_len", busy_len, e.exact_busy);
          else                   check("busy_bound", (busy_len <= MAX_BUSY), 1);
`ifdef GCD_CYCLE_COUNT_EN
          check("gcd_cycles", {24'b0, gcd_cycles}, (busy_len > 255) ? 255 : busy_len);
`endif
        end
        busy_len = 0;
      end
      busy_prev = gcd_busy;
    end
  end

  initial begin
    exp_t e;
    #2;
    check("reset_busy", {31'b0, gcd_busy}, 0);
    check("reset_return", gcd_return, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    call(32'd48, 32'd18, 32'd6, 0, 0);
    call(32'd0, 32'd35, 32'd35, 1, 0);
    call(32'd0, 32'd0, 32'd0, 1, 0);
    call(32'd35, 32'd0, 32'd35, 1, 0);
    call(32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 36, 0);
    call(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 0, 0);
    call(32'd1, 32'd1, 32'd1, 0, 0);
    call(32'd17, 32'd51, 32'd17, 0, 0);
    call(32'd270, 32'd192, 32'd6, 0, 0);
    call(32'd1071, 32'd462, 32'd21, 0, 0);

    // held req: back-to-back calls, operands swapped mid-call
    @(negedge clk);
    gcd_a = 32'd12;
    gcd_b = 32'd8;
    gcd_req = 1'b1;
    e.ret = 32'd4;  e.exact_busy = 0; sb.push_back(e);
    e.ret = 32'd1;  e.exact_busy = 0; sb.push_back(e);
    @(posedge clk);
    #1 check("held_accept", {31'b0, gcd_busy}, 1);
    repeat (2) @(negedge clk);
    gcd_a = 32'd7;
    gcd_b = 32'd5;
    wait_idle(MAX_BUSY + 8);
    @(negedge clk);
    check("b2b_gap", {31'b0, gcd_busy}, 1);
    gcd_req = 1'b0;
    wait_idle(MAX_BUSY + 8);
    repeat (3) @(negedge clk);
    check("no_third_call", {31'b0, gcd_busy}, 0);

    // reset in the middle of a long REDUCE phase discards the call
    @(negedge clk);
    gcd_a = 32'hFFFF_FFFF;
    gcd_b = 32'hFFFF_FFFE;
    gcd_req = 1'b1;
    @(posedge clk);
    #1 gcd_req = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1 check("async_reset_busy", {31'b0, gcd_busy}, 0);
    check("async_reset_return", gcd_return, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    call(32'd9, 32'd6, 32'd3, 0, 0);

    // req dropped one cycle after accept
    call(32'd100, 32'd75, 32'd25, 0, 1);
    repeat (4) @(negedge clk);
    check("req_drop_no_recall", {31'b0, gcd_busy}, 0);
    check("result_hold", gcd_return, 32'd25);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
